// File: rtl/qos_vc_tx.sv
// qos_vc_tx: four-VC transmit stage feeding the QoS receiver, with round-robin issue.
// Optional QoS error counter is enabled by defining QOS_VC_TX_ERR_CNT_EN.
module qos_vc_tx #(
  parameter int DATA_WIDTH     = 4,
  parameter int QUEUE_QUANTITY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            vc_in,
  input  logic                  push,
  input  logic [3:0]            pausa_qos,
  input  logic [3:0]            continue_qos,
  input  logic [3:0]            error_full_qos,
  output logic [DATA_WIDTH-1:0] output_tx,
  output logic [1:0]            vc_id,
  output logic                  valid_tx,
  output logic [3:0]            full_tx,
  output logic [3:0]            paused,
  output logic                  idle_tx,
  output logic [7:0]            err_count
);

  localparam int NVC = QUEUE_QUANTITY;

  logic [DATA_WIDTH-1:0] r_mem [NVC][2];
  logic [NVC-1:0]        r_wp;
  logic [NVC-1:0]        r_rp;
  logic [1:0]            r_cnt [NVC];
  logic [NVC-1:0]        r_paused;
  logic [1:0]            r_ptr;
  logic [DATA_WIDTH-1:0] r_out;
  logic [1:0]            r_vc;
  logic                  r_valid;

  logic [NVC-1:0] w_elig;
  logic [NVC-1:0] w_wr;
  logic [NVC-1:0] w_rd;
  logic [NVC-1:0] w_full;
  logic [NVC-1:0] w_empty;
  logic           w_found;
  logic [1:0]     w_gnt;
  logic [1:0]     w_idx;
  logic           w_pop;
  logic           w_push_ok;

  // Per-VC status decoded from the registered occupancy and pause state
  always_comb begin
    w_elig  = '0;
    w_full  = '0;
    w_empty = '0;
    for (int i = 0; i < NVC; i++) begin
      w_full[i]  = (r_cnt[i] == 2'd2);
      w_empty[i] = (r_cnt[i] == 2'd0);
      w_elig[i]  = !w_empty[i] && !r_paused[i];
    end
  end

  // Round-robin search starting one past the last granted VC
  always_comb begin
    w_found = 1'b0;
    w_gnt   = r_ptr;
    w_idx   = '0;
    for (int k = 1; k <= NVC; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_pop = enb && w_found;

  // A push to a full buffer only lands when that buffer pops on the same edge
  always_comb begin
    w_push_ok = enb && push &&
                (!w_full[vc_in] || (w_pop && (w_gnt == vc_in)));
    w_wr = '0;
    w_rd = '0;
    for (int i = 0; i < NVC; i++) begin
      w_wr[i] = w_push_ok && (vc_in == 2'(i));
      w_rd[i] = w_pop && (w_gnt == 2'(i));
    end
  end

  // Holding buffers: two-entry FIFO per VC with toggle pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < NVC; i++) begin
        r_cnt[i]    <= '0;
        r_mem[i][0] <= '0;
        r_mem[i][1] <= '0;
      end
    end else begin
      for (int i = 0; i < NVC; i++) begin
        if (w_wr[i]) begin
          r_mem[i][r_wp[i]] <= data_in;
          r_wp[i]           <= ~r_wp[i];
        end
        if (w_rd[i]) begin
          r_rp[i] <= ~r_rp[i];
        end
        case ({w_wr[i], w_rd[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 2'd1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 2'd1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Pause state: pause or overflow report sets, resume clears, set dominates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_paused <= '0;
    end else if (enb) begin
      for (int i = 0; i < NVC; i++) begin
        if (pausa_qos[i] || error_full_qos[i]) begin
          r_paused[i] <= 1'b1;
        end else if (continue_qos[i]) begin
          r_paused[i] <= 1'b0;
        end
      end
    end
  end

  // Issue register: word, VC and valid, plus the round-robin pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_vc    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= 2'd3;
    end else if (w_pop) begin
      r_out   <= r_mem[w_gnt][r_rp[w_gnt]];
      r_vc    <= w_gnt;
      r_valid <= 1'b1;
      r_ptr   <= w_gnt;
    end else begin
      r_valid <= 1'b0;
    end
  end

`ifdef QOS_VC_TX_ERR_CNT_EN
  logic [7:0] r_err;
  logic [2:0] w_pc;
  logic [8:0] w_sum;

  // Number of VCs reporting overflow this cycle, added to the count
  always_comb begin
    w_pc  = 3'(error_full_qos[0]) + 3'(error_full_qos[1]) +
            3'(error_full_qos[2]) + 3'(error_full_qos[3]);
    w_sum = {1'b0, r_err} + 9'(w_pc);
  end

  // Saturating error counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= '0;
    end else if (enb) begin
      r_err <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  assign err_count = r_err;
`else
  assign err_count = '0;
`endif

  assign output_tx = r_out;
  assign vc_id     = r_vc;
  assign valid_tx  = r_valid;
  assign full_tx   = w_full;
  assign paused    = r_paused;
  assign idle_tx   = (&w_empty) && !r_valid;

endmodule

// File: tb/tb_qos_vc_tx.sv
// tb_qos_vc_tx: directed checks of buffering, round-robin issue and pause.
// Error-counter expectations follow QOS_VC_TX_ERR_CNT_EN.
module tb_qos_vc_tx;

  logic       clk;
  logic       rst;
  logic       enb;
  logic [3:0] data_in;
  logic [1:0] vc_in;
  logic       push;
  logic [3:0] pausa_qos;
  logic [3:0] continue_qos;
  logic [3:0] error_full_qos;
  logic [3:0] output_tx;
  logic [1:0] vc_id;
  logic       valid_tx;
  logic [3:0] full_tx;
  logic [3:0] paused;
  logic       idle_tx;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  qos_vc_tx #(.DATA_WIDTH(4), .QUEUE_QUANTITY(4)) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .data_in(data_in), .vc_in(vc_in), .push(push),
    .pausa_qos(pausa_qos), .continue_qos(continue_qos),
    .error_full_qos(error_full_qos),
    .output_tx(output_tx), .vc_id(vc_id), .valid_tx(valid_tx),
    .full_tx(full_tx), .paused(paused), .idle_tx(idle_tx),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    enb = 1'b1; data_in = '0; vc_in = '0; push = 1'b0;
    pausa_qos = '0; continue_qos = '0; error_full_qos = '0;
  endtask

  task automatic do_reset;
    clear_in();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    clear_in();
    rst = 1'b0;
    #2;
    checks++; if (valid_tx !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_tx); end
    checks++; if (output_tx !== 4'h0) begin errors++; $display("FAIL reset_out got %h want 0", output_tx); end
    checks++; if (vc_id !== 2'd0) begin errors++; $display("FAIL reset_vc got %0d want 0", vc_id); end
    checks++; if (full_tx !== 4'b0) begin errors++; $display("FAIL reset_full got %b want 0000", full_tx); end
    checks++; if (paused !== 4'b0) begin errors++; $display("FAIL reset_paused got %b want 0000", paused); end
    checks++; if (idle_tx !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle_tx); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    push = 1'b1; vc_in = 2'd2; data_in = 4'hA;
    tick();
    push = 1'b0;
    checks++; if (valid_tx !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", valid_tx); end
    checks++; if (idle_tx !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", idle_tx); end
    tick();
    checks++; if (valid_tx !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", valid_tx); end
    checks++; if (vc_id !== 2'd2) begin errors++; $display("FAIL single_vc got %0d want 2", vc_id); end
    checks++; if (output_tx !== 4'hA) begin errors++; $display("FAIL single_out got %h want a", output_tx); end
    tick();
    checks++; if (valid_tx !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", valid_tx); end
    checks++; if (idle_tx !== 1'b1) begin errors++; $display("FAIL single_idle got %b want 1", idle_tx); end
    checks++; if (output_tx !== 4'hA) begin errors++; $display("FAIL single_hold got %h want a", output_tx); end
  endtask

  task automatic test_round_robin;
    logic [1:0] ev;
    logic [3:0] ed;
    do_reset();
    pausa_qos = 4'b1111;
    tick();
    pausa_qos = '0;
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 2; j++) begin
        push = 1'b1; vc_in = 2'(v); data_in = 4'(v * 2 + j);
        tick();
      end
    end
    push = 1'b0;
    checks++; if (valid_tx !== 1'b0) begin errors++; $display("FAIL rr_hold got %b want 0", valid_tx); end
    checks++; if (full_tx !== 4'b1111) begin errors++; $display("FAIL rr_full got %b want 1111", full_tx); end
    continue_qos = 4'b1111;
    tick();
    continue_qos = '0;
    checks++; if (paused !== 4'b0) begin errors++; $display("FAIL rr_resume got %b want 0000", paused); end
    for (int k = 0; k < 8; k++) begin
      ev = 2'(k % 4);
      ed = 4'((k % 4) * 2 + k / 4);
      tick();
      checks++; if (valid_tx !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b want 1", k, valid_tx); end
      checks++; if (vc_id !== ev) begin errors++; $display("FAIL rr_vc[%0d] got %0d want %0d", k, vc_id, ev); end
      checks++; if (output_tx !== ed) begin errors++; $display("FAIL rr_out[%0d] got %h want %h", k, output_tx, ed); end
    end
    tick();
    checks++; if (idle_tx !== 1'b1) begin errors++; $display("FAIL rr_idle got %b want 1", idle_tx); end
  endtask

  task automatic test_full;
    do_reset();
    pausa_qos = 4'b0010;
    tick();
    pausa_qos = '0;
    push = 1'b1; vc_in = 2'd1; data_in = 4'h3;
    tick();
    data_in = 4'h6;
    tick();
    checks++; if (full_tx !== 4'b0010) begin errors++; $display("FAIL full_set got %b want 0010", full_tx); end
    data_in = 4'h5;
    tick();
    push = 1'b0;
    checks++; if (full_tx !== 4'b0010) begin errors++; $display("FAIL full_drop got %b want 0010", full_tx); end
    continue_qos = 4'b0010;
    tick();
    continue_qos = '0;
    checks++; if (valid_tx !== 1'b0) begin errors++; $display("FAIL full_paused got %b want 0", valid_tx); end
    push = 1'b1; vc_in = 2'd1; data_in = 4'h9;
    tick();
    push = 1'b0;
    checks++; if (output_tx !== 4'h3 || valid_tx !== 1'b1) begin errors++; $display("FAIL full_w0 got %h/%b want 3/1", output_tx, valid_tx); end
    checks++; if (full_tx !== 4'b0010) begin errors++; $display("FAIL full_pushpop got %b want 0010", full_tx); end
    tick();
    checks++; if (output_tx !== 4'h6 || valid_tx !== 1'b1) begin errors++; $display("FAIL full_w1 got %h/%b want 6/1", output_tx, valid_tx); end
    checks++; if (full_tx !== 4'b0000) begin errors++; $display("FAIL full_clr got %b want 0000", full_tx); end
    tick();
    checks++; if (output_tx !== 4'h9 || valid_tx !== 1'b1) begin errors++; $display("FAIL full_w2 got %h/%b want 9/1", output_tx, valid_tx); end
    tick();
    checks++; if (valid_tx !== 1'b0 || idle_tx !== 1'b1) begin errors++; $display("FAIL full_end got %b/%b want 0/1", valid_tx, idle_tx); end
  endtask

  task automatic test_pause_tie;
    do_reset();
    push = 1'b1; vc_in = 2'd0; data_in = 4'hC;
    pausa_qos = 4'b0001; continue_qos = 4'b0001;
    tick();
    push = 1'b0; pausa_qos = '0; continue_qos = '0;
    checks++; if (paused !== 4'b0001) begin errors++; $display("FAIL tie_paused got %b want 0001", paused); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (valid_tx !== 1'b0) begin errors++; $display("FAIL tie_block[%0d] got %b want 0", k, valid_tx); end
    end
    continue_qos = 4'b0001;
    tick();
    continue_qos = '0;
    checks++; if (paused !== 4'b0000 || valid_tx !== 1'b0) begin errors++; $display("FAIL tie_resume got %b/%b want 0000/0", paused, valid_tx); end
    tick();
    checks++; if (valid_tx !== 1'b1 || vc_id !== 2'd0 || output_tx !== 4'hC) begin errors++; $display("FAIL tie_issue got %b/%0d/%h want 1/0/c", valid_tx, vc_id, output_tx); end
  endtask

  task automatic test_err_count;
    logic [7:0] e1;
    logic [7:0] ef;
`ifdef QOS_VC_TX_ERR_CNT_EN
    e1 = 8'd4;
    ef = 8'd255;
`else
    e1 = 8'd0;
    ef = 8'd0;
`endif
    do_reset();
    error_full_qos = 4'b1111;
    tick();
    checks++; if (err_count !== e1) begin errors++; $display("FAIL err_first got %0d want %0d", err_count, e1); end
    for (int k = 1; k < 70; k++) tick();
    error_full_qos = '0;
    checks++; if (err_count !== ef) begin errors++; $display("FAIL err_sat got %0d want %0d", err_count, ef); end
    checks++; if (paused !== 4'b1111) begin errors++; $display("FAIL err_paused got %b want 1111", paused); end
    tick();
    checks++; if (err_count !== ef) begin errors++; $display("FAIL err_hold got %0d want %0d", err_count, ef); end
  endtask

  task automatic test_async_reset;
    do_reset();
    pausa_qos = 4'b0111;
    tick();
    pausa_qos = '0;
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < 2; j++) begin
        push = 1'b1; vc_in = 2'(v); data_in = 4'(8 + v * 2 + j);
        tick();
      end
    end
    push = 1'b0;
    continue_qos = 4'b0111;
    tick();
    continue_qos = '0;
    tick();
    checks++; if (valid_tx !== 1'b1 || output_tx !== 4'h8) begin errors++; $display("FAIL arst_pre got %b/%h want 1/8", valid_tx, output_tx); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (valid_tx !== 1'b0 || output_tx !== 4'h0 || vc_id !== 2'd0) begin errors++; $display("FAIL arst_out got %b/%h/%0d want 0/0/0", valid_tx, output_tx, vc_id); end
    checks++; if (full_tx !== 4'b0 || paused !== 4'b0 || idle_tx !== 1'b1) begin errors++; $display("FAIL arst_stat got %b/%b/%b want 0000/0000/1", full_tx, paused, idle_tx); end
    rst = 1'b1;
    tick();
    checks++; if (valid_tx !== 1'b0 || idle_tx !== 1'b1) begin errors++; $display("FAIL arst_post got %b/%b want 0/1", valid_tx, idle_tx); end
    tick();
    checks++; if (valid_tx !== 1'b0) begin errors++; $display("FAIL arst_flush got %b want 0", valid_tx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_pause_tie();
    test_err_count();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qos_vc_tx.md
QOS_VC_TX -- requirements
Module: qos_vc_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of one data word.
REQ-002 Parameter QUEUE_QUANTITY, default 4, number of virtual channels; fixed at 4, matching the 2-bit vc_id.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-low.
REQ-005 Port enb, input, 1, global enable; when 0, state holds and no word is issued.
REQ-006 Port data_in, input, DATA_WIDTH, upstream word to send.
REQ-007 Port vc_in, input, 2, target VC of data_in.
REQ-008 Port push, input, 1, data_in/vc_in valid this cycle.
REQ-009 Port pausa_qos, input, 4, per-VC pause request from the QoS receiver.
REQ-010 Port continue_qos, input, 4, per-VC resume from the QoS receiver.
REQ-011 Port error_full_qos, input, 4, per-VC overflow report from the QoS receiver.
REQ-012 Port output_tx, output, DATA_WIDTH, word toward the QoS input_qos.
REQ-013 Port vc_id, output, 2, VC of output_tx.
REQ-014 Port valid_tx, output, 1, output_tx/vc_id valid; drives the QoS write enable.
REQ-015 Port full_tx, output, 4, per-VC holding buffer full.
REQ-016 Port paused, output, 4, per-VC pause state.
REQ-017 Port idle_tx, output, 1, all buffers empty and valid_tx low.
REQ-018 Port err_count, output, 8, QoS error count (see Configuration).

Function
REQ-019 Each VC SHALL have a 2-entry FIFO holding buffer; push with enb writes data_in into buffer vc_in.
REQ-020 A push to a full buffer SHALL be dropped; buffer contents are unchanged.
REQ-021 full_tx[i] SHALL be 1 exactly when buffer i holds 2 entries, registered.
REQ-022 Per-VC pause state: pausa_qos[i] or error_full_qos[i] sets paused[i] next cycle; continue_qos[i] clears it; set wins when both are asserted in the same cycle.
REQ-023 Eligible VC: buffer non-empty and paused[i]=0, both evaluated on current registered state.
REQ-024 Arbiter SHALL be round-robin: search starts at last-granted VC+1, mod 4, ascending; after reset the pointer is 3, so VC0 is searched first.
REQ-025 At most one word issued per cycle; the granted buffer pops in the same edge that registers output_tx, vc_id and valid_tx=1.
REQ-026 Latency: a word pushed into an empty, unpaused, uncontested VC at edge N appears with valid_tx=1 after edge N+1.
REQ-027 No eligible VC or enb=0: valid_tx=0 next cycle, output_tx and vc_id hold their last values.
REQ-028 Push and pop on the same buffer in the same cycle: both succeed, count unchanged, even when full.
REQ-029 A pause arriving while a word is already registered does not retract that word; it stops further grants from the next edge.

Reset
REQ-030 rst=0 SHALL asynchronously clear all buffers and counters; output_tx=0, vc_id=0, valid_tx=0, full_tx=0, paused=0, idle_tx=1, err_count=0, RR pointer=3.
REQ-031 Reset mid-transfer SHALL discard all buffered words; no word is issued on the first edge after release.

Configuration
REQ-032 Macro QOS_VC_TX_ERR_CNT_EN defined: err_count increments by the popcount of error_full_qos each enb cycle, saturating at 255.
REQ-033 Macro not defined: err_count is tied to 0 and no counter logic exists; all other behaviour is identical.

Verification
REQ-034 Push 0xA on VC2, no pause -> valid_tx=1, vc_id=2, output_tx=0xA exactly one cycle later; idle_tx returns to 1 the following cycle.
REQ-035 Two words on each of VC0..VC3, pushed before any grant -> issue order of vc_id is 0,1,2,3,0,1,2,3 with no gaps.
REQ-036 Fill VC1 (2 pushes), third push 0x5 -> full_tx[1]=1, 0x5 never appears on output.
REQ-037 pausa_qos[0] and continue_qos[0] in the same cycle with VC0 loaded -> paused[0]=1, no VC0 grant until continue_qos[0] alone is asserted.
REQ-038 With QOS_VC_TX_ERR_CNT_EN, error_full_qos=4'b1111 for 70 cycles -> err_count=255 and paused=4'b1111; without the macro, err_count=0.
REQ-039 Assert rst low while 3 VCs are loaded and valid_tx=1 -> all outputs take their reset values immediately, without waiting for a clk edge.
